// File: rtl/onehot_decoder_seq.sv
// onehot_decoder_seq: registered SEL_W-to-2**SEL_W one-hot decoder with
// valid/ready handshakes on both sides.
// - DIRECT mode: one decoded word per accepted select, at up to one word per cycle.
// - STEP mode: walks the one-hot bit upward from the start index to STEP_MAX.
//   The block stops taking new input until that walk ends.
// STEP_MAX must be below 2**SEL_W, and SEL_W must be at least 1.
module onehot_decoder_seq #(
  parameter int SEL_W    = 2,
  parameter int STEP_MAX = 2**SEL_W - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2**SEL_W-1:0]   F,
  output logic [SEL_W-1:0]      idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_STEP   = 2'd2
  } state_e;

  // Last index of a STEP walk, sized to the index arithmetic.
  localparam logic [SEL_W-1:0] STEP_LAST = SEL_W'(STEP_MAX);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;
  // Goes high on the first edge after reset release. It holds in_ready low
  // for that one cycle, so nothing is accepted in the cycle reset lifts.
  logic             live_q;

  logic accept;
  logic emit;

  assign in_ready  = live_q & (state_q != ST_STEP) & (~valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign emit      = valid_q & out_ready;
  assign out_valid = valid_q;
  assign idx       = idx_q;

  // Next-state logic: load on accept, then advance or retire the word on emit.
  always_comb begin
    // NOTE: every variable gets its hold value first. Paths that do not
    // assign it then keep the register, and no latch is inferred.
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d   = sel;
          valid_d = 1'b1;
          state_d = mode ? ST_STEP : ST_DIRECT;
        end
      end

      ST_DIRECT: begin
        if (emit) begin
          if (accept) begin
            // Emit and reload in the same cycle. out_valid never drops.
            idx_d   = sel;
            state_d = mode ? ST_STEP : ST_DIRECT;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      ST_STEP: begin
        if (emit) begin
          if (idx_q < STEP_LAST) begin
            idx_d = idx_q + SEL_W'(1);
          end else begin
            // This also covers a start index above STEP_LAST: that start
            // emits exactly one word instead of wrapping.
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, index and valid registers. Reset is asynchronous, so a STEP walk
  // in progress is dropped as soon as rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      valid_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. Every register
      // then samples the values from before the edge, whatever order the
      // statements are written in.
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      live_q  <= 1'b1;
    end
  end

  // One-hot decode of the held index, gated so F is all-zero while idle.
  always_comb begin
    F = '0;
    if (valid_q) begin
      F[idx_q] = 1'b1;
    end
  end

endmodule
